// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, round constants K[0:63],
// initial hash values H0..H7 and the fixed block geometry.
package sha256_pkg;

   localparam int ROUNDS     = 64;
   localparam int LOAD_WORDS = 16;
   localparam int T_W        = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_LOAD,
      ST_EXPAND,
      ST_UPDATE
   } state_t;

   localparam logic [31:0] K [0:ROUNDS-1] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Initial hash value, loaded into H by ld_iv on the first block of a message.
   localparam logic [31:0] H0 = 32'h6a09e667;
   localparam logic [31:0] H1 = 32'hbb67ae85;
   localparam logic [31:0] H2 = 32'h3c6ef372;
   localparam logic [31:0] H3 = 32'ha54ff53a;
   localparam logic [31:0] H4 = 32'h510e527f;
   localparam logic [31:0] H5 = 32'h9b05688c;
   localparam logic [31:0] H6 = 32'h1f83d9ab;
   localparam logic [31:0] H7 = 32'h5be0cd19;

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup t -> K[t]; kept separate so an unrolled
// core can instantiate one per round.
module sha256_k_rom
   import sha256_pkg::*;
(
   input  logic [T_W-1:0] t,
   output logic [31:0]    k
);

   assign k = K[t];

endmodule

// File: rtl/sha256_ctrl.sv
// Per-block SHA-256 sequencer: INIT -> LOAD (16 words) -> EXPAND (48 rounds) -> UPDATE.
// Optional saturating performance counters are built when SHA256_PERF_CNT_EN is defined.
module sha256_ctrl
   import sha256_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             blk_start,
   input  logic             blk_first,
   input  logic             blk_last,
   output logic             blk_ready,
   input  logic             abort,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             w_wr_en,
   output logic [31:0]      w_data,
   output logic [T_W-1:0]   t,
   output logic [31:0]      k,
   output logic             ld_iv,
   output logic             ld_work,
   output logic             rnd_en,
   output logic             h_update,
   output logic             blk_done,
   output logic             digest_valid,
   output logic [CNT_W-1:0] blk_count,
   output logic [CNT_W-1:0] stall_count
);

   state_t         state;
   state_t         state_nxt;
   logic [T_W-1:0] t_q;
   logic           first_q;
   logic           last_q;
   logic           blk_ready_q;
   logic           ld_work_q;
   logic           load_q;
   logic           expand_q;
   logic           update_q;
   logic           accept;

   // Abort wins over a word handshake in the same cycle.
   assign in_ready = load_q & ~abort;
   assign accept   = in_valid & in_ready;
   assign w_wr_en  = accept;
   assign w_data   = in_data;

   assign t            = t_q;
   assign blk_ready    = blk_ready_q;
   assign ld_work      = ld_work_q;
   assign ld_iv        = ld_work_q & first_q;
   assign rnd_en       = expand_q | accept;
   assign h_update     = update_q;
   assign blk_done     = update_q;
   assign digest_valid = update_q & last_q;

   sha256_k_rom u_k_rom (
      .t (t_q),
      .k (k)
   );

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (blk_start) state_nxt = ST_INIT;
         ST_INIT:   state_nxt = ST_LOAD;
         ST_LOAD:   if (accept && t_q == T_W'(LOAD_WORDS - 1)) state_nxt = ST_EXPAND;
         ST_EXPAND: if (t_q == T_W'(ROUNDS - 1)) state_nxt = ST_UPDATE;
         ST_UPDATE: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   // Strobes are registered from the next state so each one is a clean flop output
   // that is high exactly while the FSM sits in the matching state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         t_q         <= '0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         blk_ready_q <= 1'b1;
         ld_work_q   <= 1'b0;
         load_q      <= 1'b0;
         expand_q    <= 1'b0;
         update_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state       <= state_nxt;
         blk_ready_q <= (state_nxt == ST_IDLE);
         ld_work_q   <= (state_nxt == ST_INIT);
         load_q      <= (state_nxt == ST_LOAD);
         expand_q    <= (state_nxt == ST_EXPAND);
         update_q    <= (state_nxt == ST_UPDATE);

         if (state == ST_IDLE && blk_start && !abort) begin
            first_q <= blk_first;
            last_q  <= blk_last;
         end

         if (abort) begin
            t_q <= '0;
         end else begin
            unique case (state)
               ST_INIT:   t_q <= '0;
               ST_LOAD:   if (accept) t_q <= t_q + T_W'(1);
               ST_EXPAND: t_q <= t_q + T_W'(1);  // 63 wraps to 0 on entry to UPDATE
               default:   t_q <= t_q;
            endcase
         end
      end
   end

`ifdef SHA256_PERF_CNT_EN
   logic [CNT_W-1:0] blk_cnt_q;
   logic [CNT_W-1:0] stall_cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         blk_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (update_q && !(&blk_cnt_q))
            blk_cnt_q <= blk_cnt_q + CNT_W'(1);
         if (load_q && !in_valid && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign blk_count   = blk_cnt_q;
   assign stall_count = stall_cnt_q;
`else
   assign blk_count   = '0;
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_sha256_ctrl.sv
// Directed bench for sha256_ctrl: round indices, K values, load strobes and block
// completions are scoreboarded against expectations queued when each block is issued.
module tb_sha256_ctrl;

   localparam int CNT_W = 32;
`ifdef SHA256_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             clk       = 1'b0;
   logic             resetn    = 1'b0;
   logic             blk_start = 1'b0;
   logic             blk_first = 1'b0;
   logic             blk_last  = 1'b0;
   logic             abort     = 1'b0;
   logic [31:0]      in_data   = '0;
   logic             in_valid  = 1'b0;
   logic             blk_ready;
   logic             in_ready;
   logic             w_wr_en;
   logic [31:0]      w_data;
   logic [5:0]       t;
   logic [31:0]      k;
   logic             ld_iv;
   logic             ld_work;
   logic             rnd_en;
   logic             h_update;
   logic             blk_done;
   logic             digest_valid;
   logic [CNT_W-1:0] blk_count;
   logic [CNT_W-1:0] stall_count;

   sha256_ctrl #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .blk_start    (blk_start),
      .blk_first    (blk_first),
      .blk_last     (blk_last),
      .blk_ready    (blk_ready),
      .abort        (abort),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .w_wr_en      (w_wr_en),
      .w_data       (w_data),
      .t            (t),
      .k            (k),
      .ld_iv        (ld_iv),
      .ld_work      (ld_work),
      .rnd_en       (rnd_en),
      .h_update     (h_update),
      .blk_done     (blk_done),
      .digest_valid (digest_valid),
      .blk_count    (blk_count),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   logic [31:0] k_ref [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Padded single-block message for "abc".
   logic [31:0] msg [0:15] = '{0: 32'h61626380, 15: 32'h00000018, default: 32'h00000000};

   typedef struct {
      logic last;
      int   lat;
   } done_t;

   logic [5:0] exp_t  [$];
   logic       exp_ld [$];
   done_t      exp_done [$];

   int   n_checks   = 0;
   int   n_errors   = 0;
   int   cyc        = 0;
   int   start_cyc  = 0;
   int   prev_start = 0;
   int   w_idx      = 0;
   logic done_seen  = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Output monitor, sampled mid-cycle.
   logic [5:0] mon_t;
   done_t      mon_d;
   always @(negedge clk) begin
      if (resetn) begin
         check("h_update_vs_blk_done", h_update, blk_done);
         if (ld_work) begin
            if (exp_ld.size() == 0) check("ld_work_unexpected", 1'b1, 1'b0);
            else check("ld_iv", ld_iv, exp_ld.pop_front());
            check("t_in_init", t, 6'd0);
            w_idx = 0;
         end
         if (w_wr_en) begin
            if (w_idx < 16) check("w_data", w_data, msg[w_idx]);
            else check("w_wr_en_extra", 1'b1, 1'b0);
            w_idx++;
         end
         if (rnd_en && !abort) begin
            if (exp_t.size() == 0) check("rnd_en_unexpected", 1'b1, 1'b0);
            else begin
               mon_t = exp_t.pop_front();
               check("rnd_t", t, mon_t);
               check("k_of_t", k, k_ref[mon_t]);
            end
         end
         if (blk_done) begin
            if (exp_done.size() == 0) check("blk_done_unexpected", 1'b1, 1'b0);
            else begin
               mon_d = exp_done.pop_front();
               check("digest_valid", digest_valid, mon_d.last);
               check("latency", cyc - start_cyc, mon_d.lat);
               check("w_wr_en_count", w_idx, 16);
               check("rnd_en_count_left", exp_t.size(), 0);
            end
            done_seen = 1'b1;
         end else begin
            check("digest_without_done", digest_valid, 1'b0);
         end
      end
   end

   task automatic run_block(input logic first, input logic last, input int stall_len,
                            input int abort_t, input int poke_t, input int reset_t,
                            input int exp_lat);
      int   i;
      int   guard;
      logic acc;
      guard = 0;
      while (!blk_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("ready_before_start", blk_ready, 1'b1);
      for (int j = 0; j < ((abort_t >= 0) ? abort_t : 64); j++) exp_t.push_back(6'(j));
      exp_ld.push_back(first);
      if (abort_t < 0 && reset_t < 0) exp_done.push_back('{last, exp_lat});
      done_seen  = 1'b0;
      blk_first  = first;
      blk_last   = last;
      blk_start  = 1'b1;
      prev_start = start_cyc;
      start_cyc  = cyc;
      @(posedge clk); #1;
      blk_start = 1'b0;

      i = 0;
      guard = 0;
      while (i < 16 && guard < 100) begin
         in_valid = 1'b1;
         in_data  = msg[i];
         @(negedge clk);
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         guard++;
         if (acc) i++;
         if (i == reset_t) begin
            check("t_before_reset", t, 6'(reset_t));
            resetn = 1'b0;
            #1;
            check("reset_t", t, 6'd0);
            check("reset_strobes", {in_ready, w_wr_en, rnd_en, ld_iv, ld_work, h_update,
                                    blk_done, digest_valid}, 8'h00);
            check("reset_counters", {blk_count, stall_count}, 64'h0);
            exp_t.delete();
            exp_ld.delete();
            exp_done.delete();
            in_valid = 1'b0;
            @(posedge clk); #1;
            resetn = 1'b1;
            @(negedge clk);
            check("ready_after_reset", blk_ready, 1'b1);
            @(posedge clk); #1;
            return;
         end
         if (acc && i == 6 && stall_len > 0) begin
            in_valid = 1'b0;
            repeat (stall_len) begin
               @(negedge clk);
               check("stall_rnd_en", rnd_en, 1'b0);
               check("stall_t", t, 6'd6);
               @(posedge clk); #1;
            end
         end
      end
      in_valid = 1'b0;
      check("words_fed", i, 16);

      guard = 0;
      while (!done_seen && guard < 80) begin
         if (abort_t >= 0 && int'(t) == abort_t) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check("abort_ready", blk_ready, 1'b1);
            check("abort_t", t, 6'd0);
            check("abort_rnd_left", exp_t.size(), 0);
            repeat (3) begin
               @(negedge clk);
               check("abort_no_h_update", h_update, 1'b0);
            end
            @(posedge clk); #1;
            return;
         end
         if (poke_t >= 0 && int'(t) == poke_t) begin
            check("poke_not_ready", blk_ready, 1'b0);
            blk_start = 1'b1;
            @(posedge clk); #1;
            blk_start = 1'b0;
            check("poke_still_not_ready", blk_ready, 1'b0);
         end else begin
            @(posedge clk); #1;
         end
         guard++;
      end
      check("block_done_seen", done_seen, 1'b1);
   endtask

   initial begin
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("por_t", t, 6'd0);
      check("por_strobes", {in_ready, w_wr_en, rnd_en, ld_iv, ld_work, h_update,
                            blk_done, digest_valid}, 8'h00);
      check("por_counters", {blk_count, stall_count}, 64'h0);
      resetn = 1'b1;
      @(negedge clk);
      check("por_ready", blk_ready, 1'b1);
      @(posedge clk); #1;

      // Single-block "abc", then the same block with a 3-cycle input gap after word 5.
      run_block(1'b1, 1'b1, 0, -1, -1, -1, 66);
      run_block(1'b1, 1'b1, 3, -1, -1, -1, 69);
      check("stall_count", stall_count, PERF ? 32'd3 : 32'd0);
      check("blk_count_after_two", blk_count, PERF ? 32'd2 : 32'd0);

      // Asynchronous reset while loading word t=10.
      run_block(1'b1, 1'b0, 0, -1, -1, 10, 0);

      // Two-block message, issued back to back.
      run_block(1'b1, 1'b0, 0, -1, -1, -1, 66);
      run_block(1'b0, 1'b1, 0, -1, -1, -1, 66);
      check("back_to_back_period", start_cyc - prev_start, 67);
      check("blk_count_two_block", blk_count, PERF ? 32'd2 : 32'd0);

      // Abort at t=30, then a fresh block must complete normally.
      run_block(1'b1, 1'b1, 0, 30, -1, -1, 0);
      run_block(1'b1, 1'b1, 0, -1, -1, -1, 66);

      // blk_start while in EXPAND is ignored.
      run_block(1'b1, 1'b1, 0, -1, 40, -1, 66);

      repeat (80) @(posedge clk);
      #1;
      check("idle_ready_at_end", blk_ready, 1'b1);
      check("exp_t_empty", exp_t.size(), 0);
      check("exp_ld_empty", exp_ld.size(), 0);
      check("exp_done_empty", exp_done.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
